alu_struct_2: RTL and testbench
===============================

ALU_STRUCT_2 -- requirements
Module: alu_struct_2

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; all behaviour below is stated for WIDTH=16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B.
REQ-006 cin  input  1  carry/borrow-in and shift fill bit.
REQ-007 opcode  input  3  operation select.
REQ-008 w  output  WIDTH  registered result.
REQ-009 zero  output  1  registered flag: w == 0.
REQ-010 neg  output  1  registered flag: w[WIDTH-1].
REQ-011 Positional port order SHALL be clk, rst, a, b, cin, opcode, w, zero, neg.

Function
REQ-012 opcode 000 ADD: w = a + b + cin, modulo 2^WIDTH.
REQ-013 opcode 001 SUB: w = a - b - cin, modulo 2^WIDTH (two's complement, a + ~b + !cin).
REQ-014 opcode 010 AND: w = a & b; cin ignored.
REQ-015 opcode 011 OR: w = a | b; cin ignored.
REQ-016 opcode 100 XOR: w = a ^ b; cin ignored.
REQ-017 opcode 101 NOT: w = ~a; b, cin ignored.
REQ-018 opcode 110 SHL: w = {a[WIDTH-2:0], cin}; b ignored.
REQ-019 opcode 111 ASR: w = {a[WIDTH-1], a[WIDTH-1:1]}; b, cin ignored.
REQ-020 Result and flags SHALL be computed combinationally from the current inputs and registered together; latency exactly 1 clk; no handshake; a new operation is accepted every cycle.
REQ-021 zero and neg SHALL always be consistent with the registered w of the same cycle.
REQ-022 No X propagation from ignored inputs; all 8 opcodes are defined (no illegal opcode).
REQ-023 Datapath SHALL be structural: a WIDTH-bit ripple/adder unit shared by ADD/SUB, a logic unit, a shift unit, and an 8:1 result mux.

Reset
REQ-024 When rst=1 at a rising clk edge: w=0, zero=1, neg=0 (ovf=0 when present), regardless of other inputs.
REQ-025 Reset asserted mid-stream SHALL discard the operation sampled that edge; the first result after release appears on the first edge with rst=0.

Configuration
REQ-026 Macro ALU_STRUCT_2_OVF_EN: when defined, adds output ovf (1 bit, after neg), registered with w; ovf=1 for ADD when a,b same sign and w sign differs, for SUB when a,b differ in sign and w sign differs from a; ovf=0 for opcodes 010-111.
REQ-027 Without ALU_STRUCT_2_OVF_EN the port does not exist and no overflow logic is synthesized; all other behaviour identical.

Verification
REQ-028 Reset: rst=1, a=0xFFFF, b=0xFFFF, opcode=000 -> after edge w=0x0000, zero=1, neg=0.
REQ-029 ADD a=0x7FFF, b=0x0001, cin=0 -> next edge w=0x8000, zero=0, neg=1 (ovf=1 if enabled); a=0xFFFF, b=0x0001, cin=0 -> w=0x0000, zero=1.
REQ-030 SUB a=0x1234, b=0x1234, cin=0 -> w=0x0000, zero=1, neg=0; cin=1 -> w=0xFFFF, neg=1.
REQ-031 Logic a=0xFFFF, b=0xFF09: AND -> 0xFF09 neg=1; OR -> 0xFFFF; XOR -> 0x00F6 neg=0; NOT -> 0x0000 zero=1.
REQ-032 Shifts: SHL a=0x8001 cin=1 -> 0x0003; ASR a=0x8002 -> 0xC001 neg=1; ASR a=0x0001 -> 0x0000 zero=1.
REQ-033 Random: drive {a,b,cin,opcode} with random values every 30 ns for at least 1000 vectors; each result, zero, neg SHALL match a reference model one clk later.

Source files
------------

// File: rtl/alu_struct_2.sv
// Registered 8-operation ALU built from an add/sub unit, a logic unit, a shift unit and an 8:1 mux.
// Optional overflow flag output ovf is enabled by defining ALU_STRUCT_2_OVF_EN.

module alu_struct_2_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s
);
  logic [WIDTH:0] c;

  // Ripple chain: each bit's sum and carry come from the previous carry.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
  end
endmodule

module alu_struct_2_logic #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_r,
  output logic [WIDTH-1:0] or_r,
  output logic [WIDTH-1:0] xor_r,
  output logic [WIDTH-1:0] not_r
);
  always_comb begin
    and_r = a & b;
    or_r  = a | b;
    xor_r = a ^ b;
    not_r = ~a;
  end
endmodule

module alu_struct_2_shift #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             fill,
  output logic [WIDTH-1:0] shl_r,
  output logic [WIDTH-1:0] asr_r
);
  always_comb begin
    shl_r = {a[WIDTH-2:0], fill};
    asr_r = {a[WIDTH-1], a[WIDTH-1:1]};
  end
endmodule

module alu_struct_2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] w,
  output logic             zero,
  output logic             neg
`ifdef ALU_STRUCT_2_OVF_EN
  ,
  output logic             ovf
`endif
);
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_ASR = 3'b111
  } op_e;

  op_e              op;
  logic             sub;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] and_r, or_r, xor_r, not_r;
  logic [WIDTH-1:0] shl_r, asr_r;
  logic [WIDTH-1:0] result;

  // SUB reuses the adder as a + ~b + !cin.
  always_comb begin
    op     = op_e'(opcode);
    sub    = (op == OP_SUB);
    add_y  = sub ? ~b : b;
    add_ci = sub ? ~cin : cin;
  end

  alu_struct_2_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x  (a),
    .y  (add_y),
    .ci (add_ci),
    .s  (add_s)
  );

  alu_struct_2_logic #(.WIDTH(WIDTH)) u_logic (
    .a     (a),
    .b     (b),
    .and_r (and_r),
    .or_r  (or_r),
    .xor_r (xor_r),
    .not_r (not_r)
  );

  alu_struct_2_shift #(.WIDTH(WIDTH)) u_shift (
    .a     (a),
    .fill  (cin),
    .shl_r (shl_r),
    .asr_r (asr_r)
  );

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD,
      OP_SUB: result = add_s;
      OP_AND: result = and_r;
      OP_OR:  result = or_r;
      OP_XOR: result = xor_r;
      OP_NOT: result = not_r;
      OP_SHL: result = shl_r;
      OP_ASR: result = asr_r;
      default: result = '0;
    endcase
  end

`ifdef ALU_STRUCT_2_OVF_EN
  logic ovf_next;

  // Overflow when the adder's two operands agree in sign but the sum does not.
  always_comb begin
    ovf_next = 1'b0;
    if (op == OP_ADD || op == OP_SUB)
      ovf_next = (a[WIDTH-1] == add_y[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= ovf_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w    <= '0;
      zero <= 1'b1;
      neg  <= 1'b0;
    end else begin
      w    <= result;
      zero <= (result == '0);
      neg  <= result[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_alu_struct_2.sv
// Self-checking bench for alu_struct_2: directed vectors plus randomized vectors against a reference model.
// Checks ovf as well when ALU_STRUCT_2_OVF_EN is defined.

module tb_alu_struct_2;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic [2:0]  opcode;
  logic [15:0] w;
  logic        zero, neg;
`ifdef ALU_STRUCT_2_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #15 clk = ~clk;

  alu_struct_2 #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .opcode (opcode),
    .w      (w),
    .zero   (zero),
    .neg    (neg)
`ifdef ALU_STRUCT_2_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tc, input logic [2:0] top);
    rst = r; a = ta; b = tb; cin = tc; opcode = top;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] ew, input logic ez,
                            input logic en, input logic eo);
    chk({tag, ".w"},    w,    ew);
    chk({tag, ".zero"}, {15'd0, zero}, {15'd0, ez});
    chk({tag, ".neg"},  {15'd0, neg},  {15'd0, en});
`ifdef ALU_STRUCT_2_OVF_EN
    chk({tag, ".ovf"},  {15'd0, ovf},  {15'd0, eo});
`endif
  endtask

  // Reference model from the arithmetic definitions; returns {ovf, w}.
  function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic [2:0] mop);
    int ua = int'(ma);
    int ub = int'(mb);
    int uc = int'(mc);
    int sa = $signed(ma);
    int sb = $signed(mb);
    int r  = 0;
    int s  = 0;
    logic o = 1'b0;
    case (mop)
      3'd0: begin r = ua + ub + uc; s = sa + sb + uc; o = (s > 32767) || (s < -32768); end
      3'd1: begin r = ua - ub - uc; s = sa - sb - uc; o = (s > 32767) || (s < -32768); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 65535 - ua;
      3'd6: r = ua * 2 + uc;
      default: r = sa >>> 1;
    endcase
    return {o, r[15:0]};
  endfunction

  initial begin
    logic [16:0] m;
    logic [15:0] ra, rb;
    logic        rc, rr;
    logic [2:0]  ro;

    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 3'b000);
    expect_res("reset", 16'h0000, 1'b1, 1'b0, 1'b0);

    step(1'b0, 16'h7FFF, 16'h0001, 1'b0, 3'b000);
    expect_res("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'hFFFF, 16'h0001, 1'b0, 3'b000);
    expect_res("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h1234, 16'h1234, 1'b0, 3'b001);
    expect_res("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h1234, 16'h1234, 1'b1, 3'b001);
    expect_res("sub_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b0);

    step(1'b0, 16'hFFFF, 16'hFF09, 1'b1, 3'b010);
    expect_res("and", 16'hFF09, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'hFFFF, 16'hFF09, 1'b1, 3'b011);
    expect_res("or", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'hFFFF, 16'hFF09, 1'b1, 3'b100);
    expect_res("xor", 16'h00F6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'hFFFF, 16'hFF09, 1'b1, 3'b101);
    expect_res("not", 16'h0000, 1'b1, 1'b0, 1'b0);

    step(1'b0, 16'h8001, 16'h5555, 1'b1, 3'b110);
    expect_res("shl", 16'h0003, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h8002, 16'h5555, 1'b1, 3'b111);
    expect_res("asr_neg", 16'hC001, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0001, 16'hAAAA, 1'b1, 3'b111);
    expect_res("asr_zero", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Mid-stream reset discards the sampled op; next edge with rst=0 delivers a result.
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 3'b000);
    expect_res("mid_reset", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h8000, 16'h0001, 1'b0, 3'b000);
    expect_res("post_reset", 16'h8001, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 1200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ro = 3'($urandom);
      rr = ($urandom_range(0, 49) == 0);
      if (i % 8 == 0) ra = (i % 16 == 0) ? 16'h7FFF : 16'h8000;
      step(rr, ra, rb, rc, ro);
      if (rr) begin
        expect_res("rand_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
      end else begin
        m = model(ra, rb, rc, ro);
        expect_res($sformatf("rand%0d_op%0d", i, ro), m[15:0], (m[15:0] == 16'h0000),
                   m[15], m[16]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
